// File: rtl/byte_sel_register.sv
// Byte-addressable register file: ADDR_WIDTH slots of DATA_WIDTH bits.
// One selected slot is written per edge. Reads are combinational, both per slot and as a flat vector.
module byte_sel_register #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_write,
  input  logic [$clog2(ADDR_WIDTH)-1:0]    i_byte_sel,
  input  logic [DATA_WIDTH-1:0]            i_data,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic [DATA_WIDTH*ADDR_WIDTH-1:0] o_full_data
);

  localparam int SEL_W = $clog2(ADDR_WIDTH);

  // Packed storage puts slot k at bits [k*DATA_WIDTH +: DATA_WIDTH] directly.
  logic [ADDR_WIDTH-1:0][DATA_WIDTH-1:0] slots;

  // Selects at or beyond ADDR_WIDTH match no slot, so such writes simply fall through.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      slots <= '0;
    end else if (i_write) begin
      for (int k = 0; k < ADDR_WIDTH; k++) begin
        if (i_byte_sel == SEL_W'(k)) begin
          slots[k] <= i_data;
        end
      end
    end
  end

  // Read mux without a bypass path; an out-of-range select reads as zero.
  always_comb begin
    o_data = '0;
    for (int k = 0; k < ADDR_WIDTH; k++) begin
      if (i_byte_sel == SEL_W'(k)) begin
        o_data = slots[k];
      end
    end
  end

  assign o_full_data = slots;

endmodule

// File: tb/tb_byte_sel_register.sv
// Self-checking bench for byte_sel_register, using directed vectors, corner sequences and randomized traffic.
// A second small instance with a non-power-of-two slot count exercises the out-of-range selects.
module tb_byte_sel_register;

  localparam int DW  = 8;
  localparam int AW  = 32;
  localparam int SW  = 5;
  localparam int FW  = DW * AW;
  localparam int DW2 = 4;
  localparam int AW2 = 6;
  localparam int SW2 = 3;
  localparam int FW2 = DW2 * AW2;

  // ---------------- clock / reset / DUTs ----------------
  logic          i_clk = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_write = 1'b0;
  logic [SW-1:0] i_byte_sel = '0;
  logic [DW-1:0] i_data = '0;
  logic [DW-1:0] o_data;
  logic [FW-1:0] o_full_data;

  logic           w2 = 1'b0;
  logic [SW2-1:0] sel2 = '0;
  logic [DW2-1:0] data2 = '0;
  logic [DW2-1:0] o_data2;
  logic [FW2-1:0] o_full2;

  always #5 i_clk = ~i_clk;

  byte_sel_register #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_write(i_write), .i_byte_sel(i_byte_sel),
    .i_data(i_data), .o_data(o_data), .o_full_data(o_full_data)
  );

  byte_sel_register #(.DATA_WIDTH(DW2), .ADDR_WIDTH(AW2)) dut2 (
    .i_clk(i_clk), .i_reset(i_reset), .i_write(w2), .i_byte_sel(sel2),
    .i_data(data2), .o_data(o_data2), .o_full_data(o_full2)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0]  exp_mem  [AW];
  logic [DW2-1:0] exp_mem2 [AW2];
  logic [FW-1:0]  exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [FW-1:0] model_full();
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < AW; k++) f[k*DW +: DW] = exp_mem[k];
    return f;
  endfunction

  function automatic logic [FW2-1:0] model_full2();
    logic [FW2-1:0] f;
    f = '0;
    for (int k = 0; k < AW2; k++) f[k*DW2 +: DW2] = exp_mem2[k];
    return f;
  endfunction

  function automatic logic [DW2-1:0] model_read2(input int s);
    return (s < AW2) ? exp_mem2[s] : '0;
  endfunction

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string name);
    exp_q.push_back(FW'(exp_mem[i_byte_sel]));
    exp_q.push_back(model_full());
    check({name, ".o_data"}, FW'(o_data), exp_q.pop_front());
    check({name, ".full"}, o_full_data, exp_q.pop_front());
  endtask

  task automatic check_outputs2(input string name);
    check({name, ".o_data2"}, FW'(o_data2), FW'(model_read2(int'(sel2))));
    check({name, ".full2"}, FW'(o_full2), FW'(model_full2()));
  endtask

  // ---------------- driver tasks ----------------
  // Apply the driven inputs to the model, then advance past the next rising edge.
  task automatic tick();
    if (i_reset) begin
      foreach (exp_mem[k]) exp_mem[k] = '0;
      foreach (exp_mem2[k]) exp_mem2[k] = '0;
    end else begin
      if (i_write) exp_mem[i_byte_sel] = i_data;
      if (w2 && int'(sel2) < AW2) exp_mem2[int'(sel2)] = data2;
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic wr, input logic [SW-1:0] sel, input logic [DW-1:0] d);
    i_reset = rst;
    i_write = wr;
    i_byte_sel = sel;
    i_data = d;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, '0, '0);
    tick();
    i_reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst;
    logic          wr;
    logic [SW-1:0] sel;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vecs[$];

  initial begin
    logic [FW-1:0] e;

    vecs.push_back('{1'b0, 1'b1, 5'd31, 8'h11, 8'h11});
    vecs.push_back('{1'b0, 1'b1, 5'd31, 8'h22, 8'h22});
    vecs.push_back('{1'b0, 1'b0, 5'd31, 8'h00, 8'h22});
    vecs.push_back('{1'b0, 1'b0, 5'd31, 8'hEE, 8'h22});
    vecs.push_back('{1'b0, 1'b0, 5'd31, 8'h00, 8'h22});
    vecs.push_back('{1'b0, 1'b1, 5'd0,  8'h7E, 8'h7E});
    vecs.push_back('{1'b0, 1'b0, 5'd5,  8'h00, 8'h00});
    vecs.push_back('{1'b0, 1'b1, 5'd5,  8'h5A, 8'h5A});
    vecs.push_back('{1'b1, 1'b1, 5'd3,  8'hFF, 8'h00});
    vecs.push_back('{1'b0, 1'b0, 5'd5,  8'h00, 8'h00});
    vecs.push_back('{1'b0, 1'b1, 5'd7,  8'hC3, 8'hC3});
    vecs.push_back('{1'b0, 1'b1, 5'd7,  8'h3C, 8'h3C});

    // Reset clears everything, whatever the select.
    drive(1'b1, 1'b0, 5'd17, '0);
    tick();
    i_reset = 1'b0;
    check("reset.full", o_full_data, '0);
    for (int k = 0; k < AW; k++) begin
      i_byte_sel = SW'(k);
      #1;
      check($sformatf("reset.o_data[%0d]", k), FW'(o_data), '0);
    end

    // The write is not visible before its edge.
    drive(1'b0, 1'b1, 5'd2, 8'h3C);
    #1;
    check("nobypass_pre", FW'(o_data), '0);
    tick();
    i_write = 1'b0;
    check("nobypass_post", FW'(o_data), FW'(8'h3C));

    // Single write lands in bits [47:40] only.
    do_reset();
    drive(1'b0, 1'b1, 5'd5, 8'hA5);
    tick();
    i_write = 1'b0;
    e = '0;
    e[47:40] = 8'hA5;
    check("single.full", o_full_data, e);
    for (int k = 0; k < AW; k++) begin
      i_byte_sel = SW'(k);
      #1;
      check($sformatf("single.o_data[%0d]", k), FW'(o_data), (k == 5) ? FW'(8'hA5) : '0);
    end

    // Directed vector table.
    do_reset();
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].wr, vecs[i].sel, vecs[i].data);
      tick();
      i_reset = 1'b0;
      i_write = 1'b0;
      #1;
      check($sformatf("vec%0d.o_data", i), FW'(o_data), FW'(vecs[i].exp));
      check($sformatf("vec%0d.full", i), o_full_data, model_full());
    end

    // Fill every slot on consecutive edges, then sweep reads.
    for (int k = 0; k < AW; k++) begin
      drive(1'b0, 1'b1, SW'(k), DW'(k + 1));
      tick();
    end
    i_write = 1'b0;
    for (int k = 0; k < AW; k++) begin
      i_byte_sel = SW'(k);
      #1;
      check($sformatf("fill.o_data[%0d]", k), FW'(o_data), FW'(k + 1));
      check($sformatf("fill.byte[%0d]", k), FW'(o_full_data[k*DW +: DW]), FW'(k + 1));
    end

    // Overwrite slot 31 back-to-back, then hold.
    drive(1'b0, 1'b1, 5'd31, 8'h11);
    tick();
    i_data = 8'h22;
    tick();
    i_write = 1'b0;
    for (int n = 0; n < 3; n++) tick();
    check("overwrite.top", FW'(o_full_data[255:248]), FW'(8'h22));
    check_outputs("overwrite");

    // Reset beats a simultaneous write.
    drive(1'b1, 1'b1, 5'd3, 8'hFF);
    tick();
    drive(1'b0, 1'b0, 5'd3, 8'h00);
    #1;
    check("rstprio.full", o_full_data, '0);
    check("rstprio.o_data", FW'(o_data), '0);

    // Out-of-range selects on the 6-slot instance: ignored writes, zero reads.
    w2 = 1'b1; sel2 = 3'd6; data2 = 4'hF;
    tick();
    sel2 = 3'd7; data2 = 4'hA;
    tick();
    sel2 = 3'd1; data2 = 4'h5;
    tick();
    w2 = 1'b0;
    check("oor.full2", FW'(o_full2), FW'(24'h000050));
    for (int s = 0; s < 8; s++) begin
      sel2 = SW2'(s);
      #1;
      check($sformatf("oor.o_data2[%0d]", s), FW'(o_data2), (s == 1) ? FW'(4'h5) : '0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
            SW'($urandom_range(0, AW - 1)), DW'($urandom));
      w2 = 1'($urandom_range(0, 1));
      sel2 = SW2'($urandom_range(0, 7));
      data2 = DW2'($urandom);
      tick();
      i_reset = 1'b0;
      i_write = 1'b0;
      w2 = 1'b0;
      i_byte_sel = SW'($urandom_range(0, AW - 1));
      sel2 = SW2'($urandom_range(0, 7));
      #1;
      check_outputs($sformatf("rand%0d", n));
      check_outputs2($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
